// File: rtl/riscv_imem_boot_ctrl.sv
// Boot loader for a RISC-V instruction memory: streams program words into imem,
// holds the core in reset while loading, then hands the read port to the core.
module riscv_imem_boot_ctrl #(
    parameter int XLEN = 32,
    parameter int AW   = 10
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_boot_start,
    input  logic [AW:0]     i_boot_len,
    input  logic [XLEN-1:0] i_boot_data,
    input  logic            i_boot_valid,
    output logic            o_boot_ready,
    output logic            o_imem_we,
    output logic [AW-1:0]   o_imem_waddr,
    output logic [XLEN-1:0] o_imem_wdata,
    input  logic [AW-1:0]   i_core_faddr,
    output logic [AW-1:0]   o_imem_raddr,
    output logic            o_core_rst,
    output logic            o_boot_done,
    output logic            o_boot_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        RELEASE = 2'd2,
        RUN     = 2'd3
    } state_t;

    localparam logic [AW:0] DEPTH   = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] LEN_ONE = {{AW{1'b0}}, 1'b1};

    state_t        state_reg, state_next;
    logic [AW-1:0] cnt_reg, cnt_next;
    logic [AW:0]   len_reg, len_next;
    logic          err_reg, err_next;

    logic len_legal;
    logic accept;
    logic last_word;

    assign len_legal = (i_boot_len != '0) && (i_boot_len <= DEPTH);
    assign accept    = (state_reg == LOAD) && i_boot_valid;
    assign last_word = ({1'b0, cnt_reg} == (len_reg - LEN_ONE));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            len_reg   <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            len_reg   <= len_next;
            err_reg   <= err_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        len_next   = len_reg;
        err_next   = 1'b0;
        case (state_reg)
            IDLE, RUN: begin
                if (i_boot_start) begin
                    if (len_legal) begin
                        state_next = LOAD;
                        cnt_next   = '0;
                        len_next   = i_boot_len;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            LOAD: begin
                err_next = i_boot_start;
                if (accept) begin
                    // Counter holds on the final word so a full-depth load never wraps to 0.
                    if (last_word) begin
                        state_next = RELEASE;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end
            RELEASE: begin
                err_next   = i_boot_start;
                state_next = RUN;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign o_boot_ready = (state_reg == LOAD);
    assign o_imem_we    = accept;
    assign o_imem_waddr = cnt_reg;
    assign o_imem_wdata = i_boot_data;
    assign o_imem_raddr = (state_reg == RUN) ? i_core_faddr : cnt_reg;
    assign o_core_rst   = (state_reg != RUN);
    assign o_boot_done  = (state_reg == RELEASE);
    assign o_boot_err   = err_reg;

endmodule

// File: tb/tb_riscv_imem_boot_ctrl.sv
// Directed bench for riscv_imem_boot_ctrl; imem writes are checked against a
// scoreboard queue filled as each program word is driven.
module tb_riscv_imem_boot_ctrl;

    localparam int XLEN  = 32;
    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;

    logic            i_clk = 1'b0;
    logic            i_rst = 1'b1;
    logic            i_boot_start = 1'b0;
    logic [AW:0]     i_boot_len = '0;
    logic [XLEN-1:0] i_boot_data = '0;
    logic            i_boot_valid = 1'b0;
    logic            o_boot_ready;
    logic            o_imem_we;
    logic [AW-1:0]   o_imem_waddr;
    logic [XLEN-1:0] o_imem_wdata;
    logic [AW-1:0]   i_core_faddr = '0;
    logic [AW-1:0]   o_imem_raddr;
    logic            o_core_rst;
    logic            o_boot_done;
    logic            o_boot_err;

    riscv_imem_boot_ctrl #(.XLEN(XLEN), .AW(AW)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_boot_start(i_boot_start),
        .i_boot_len  (i_boot_len),
        .i_boot_data (i_boot_data),
        .i_boot_valid(i_boot_valid),
        .o_boot_ready(o_boot_ready),
        .o_imem_we   (o_imem_we),
        .o_imem_waddr(o_imem_waddr),
        .o_imem_wdata(o_imem_wdata),
        .i_core_faddr(i_core_faddr),
        .o_imem_raddr(o_imem_raddr),
        .o_core_rst  (o_core_rst),
        .o_boot_done (o_boot_done),
        .o_boot_err  (o_boot_err)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_errors = 0;
    int n_writes = 0;
    int w_mark   = 0;
    logic [AW+XLEN-1:0] exp_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Any write seen must match the oldest expected word.
    task automatic mon();
        logic [AW+XLEN-1:0] e;
        if (o_imem_we === 1'b1) begin
            n_writes++;
            $display("WR addr=%0d data=%08h", o_imem_waddr, o_imem_wdata);
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 64'(exp_q.size()), 64'd1);
            end else begin
                e = exp_q.pop_front();
                chk("waddr", 64'(o_imem_waddr), 64'(e[AW+XLEN-1:XLEN]));
                chk("wdata", 64'(o_imem_wdata), 64'(e[XLEN-1:0]));
            end
        end
    endtask

    task automatic sample();
        @(negedge i_clk);
        mon();
    endtask

    task automatic adv();
        @(posedge i_clk);
        #1;
    endtask

    task automatic start(input int len);
        i_boot_start = 1'b1;
        i_boot_len   = (AW+1)'(len);
        sample();
        adv();
        i_boot_start = 1'b0;
        $display("START len=%0d", len);
    endtask

    task automatic send(input logic [XLEN-1:0] data, input int addr, input int gap);
        repeat (gap) begin
            sample();
            adv();
        end
        i_boot_valid = 1'b1;
        i_boot_data  = data;
        exp_q.push_back({AW'(addr), data});
        sample();
        chk("ready_on_word", 64'(o_boot_ready), 64'd1);
        adv();
        i_boot_valid = 1'b0;
        chk("sb_drained", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic finish_load();
        sample();
        chk("done_pulse", 64'(o_boot_done), 64'd1);
        chk("rst_in_release", 64'(o_core_rst), 64'd1);
        chk("ready_in_release", 64'(o_boot_ready), 64'd0);
        adv();
        sample();
        chk("core_run", 64'(o_core_rst), 64'd0);
        chk("done_single", 64'(o_boot_done), 64'd0);
        chk("ready_in_run", 64'(o_boot_ready), 64'd0);
        adv();
        $display("LOAD complete, core running");
    endtask

    initial begin
        // Reset state
        sample();
        chk("rst_core_rst", 64'(o_core_rst), 64'd1);
        chk("rst_ready", 64'(o_boot_ready), 64'd0);
        chk("rst_we", 64'(o_imem_we), 64'd0);
        chk("rst_done", 64'(o_boot_done), 64'd0);
        chk("rst_err", 64'(o_boot_err), 64'd0);
        chk("rst_waddr", 64'(o_imem_waddr), 64'd0);
        i_rst = 1'b0;
        adv();

        // Illegal lengths in IDLE
        start(0);
        sample();
        chk("err_len0", 64'(o_boot_err), 64'd1);
        chk("idle_ready_len0", 64'(o_boot_ready), 64'd0);
        chk("idle_core_rst", 64'(o_core_rst), 64'd1);
        adv();
        sample();
        chk("err_len0_single", 64'(o_boot_err), 64'd0);
        chk("idle_ready_after", 64'(o_boot_ready), 64'd0);
        adv();
        start(DEPTH + 1);
        sample();
        chk("err_len_big", 64'(o_boot_err), 64'd1);
        chk("idle_ready_big", 64'(o_boot_ready), 64'd0);
        adv();

        // len=4 back-to-back
        start(4);
        for (int i = 0; i < 4; i++) send(32'hA0 + 32'(i), i, 0);
        finish_load();

        // len=3 with valid gaps
        w_mark = n_writes;
        start(3);
        send(32'hB0, 0, 0);
        send(32'hB1, 1, 2);
        send(32'hB2, 2, 5);
        finish_load();
        chk("gap_write_count", 64'(n_writes - w_mark), 64'd3);

        // start during LOAD is rejected
        start(8);
        for (int i = 0; i < 3; i++) send(32'hC0 + 32'(i), i, 0);
        start(2);
        sample();
        chk("err_in_load", 64'(o_boot_err), 64'd1);
        chk("still_loading", 64'(o_boot_ready), 64'd1);
        adv();
        for (int i = 3; i < 8; i++) send(32'hC0 + 32'(i), i, 0);
        finish_load();

        // Fetch path in RUN, then reload
        for (int f = 0; f < 16; f++) begin
            i_core_faddr = AW'(f);
            sample();
            chk("raddr_follow", 64'(o_imem_raddr), 64'(f));
            adv();
        end
        start(2);
        sample();
        chk("reload_core_rst", 64'(o_core_rst), 64'd1);
        chk("reload_ready", 64'(o_boot_ready), 64'd1);
        chk("reload_raddr", 64'(o_imem_raddr), 64'd0);
        adv();
        send(32'hD0, 0, 0);
        send(32'hD1, 1, 0);
        finish_load();

        // Asynchronous reset mid-load
        start(6);
        send(32'hE0, 0, 0);
        send(32'hE1, 1, 0);
        i_boot_valid = 1'b1;
        i_boot_data  = 32'hE2;
        #2;
        i_rst = 1'b1;
        #1;
        chk("arst_core_rst", 64'(o_core_rst), 64'd1);
        chk("arst_ready", 64'(o_boot_ready), 64'd0);
        chk("arst_we", 64'(o_imem_we), 64'd0);
        chk("arst_done", 64'(o_boot_done), 64'd0);
        chk("arst_err", 64'(o_boot_err), 64'd0);
        chk("arst_waddr", 64'(o_imem_waddr), 64'd0);
        #1;
        i_rst = 1'b0;
        $display("RESET pulse mid-load");
        for (int i = 0; i < 3; i++) begin
            sample();
            chk("idle_after_arst", 64'(o_boot_ready), 64'd0);
            adv();
        end
        i_boot_valid = 1'b0;

        // Full-depth load
        w_mark = n_writes;
        start(DEPTH);
        for (int i = 0; i < DEPTH; i++) send($urandom, i, 0);
        finish_load();
        chk("full_write_count", 64'(n_writes - w_mark), 64'(DEPTH));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/riscv_imem_boot_ctrl.md
RISCV_IMEM_BOOT_CTRL -- requirements
Module: riscv_imem_boot_ctrl

Interface
REQ-001 SHALL provide parameter XLEN, default 32, instruction word width.
REQ-002 SHALL provide parameter AW, default 10, imem word-address width (depth 2**AW words).
REQ-003 SHALL use a single clock and an asynchronous, active-high reset; every flop SHALL be clocked by i_clk and reset by i_rst.
REQ-004 i_clk  in  1  clock.
REQ-005 i_rst  in  1  asynchronous active-high reset.
REQ-006 i_boot_start  in  1  one-cycle request to (re)load the program.
REQ-007 i_boot_len  in  AW+1  number of words to load, legal range 1..2**AW, sampled with i_boot_start.
REQ-008 i_boot_data  in  XLEN  incoming program word.
REQ-009 i_boot_valid  in  1  i_boot_data valid.
REQ-010 o_boot_ready  out  1  controller accepts a word this cycle.
REQ-011 o_imem_we  out  1  imem write enable.
REQ-012 o_imem_waddr  out  AW  imem write word address.
REQ-013 o_imem_wdata  out  XLEN  imem write data.
REQ-014 i_core_faddr  in  AW  core fetch word address.
REQ-015 o_imem_raddr  out  AW  word address driven to imem read port.
REQ-016 o_core_rst  out  1  hold-in-reset for the core.
REQ-017 o_boot_done  out  1  one-cycle pulse when load completes.
REQ-018 o_boot_err  out  1  one-cycle pulse on an illegal start request.

Function
REQ-019 SHALL implement FSM states IDLE, LOAD, RELEASE, RUN.
REQ-020 IDLE: o_core_rst=1, o_boot_ready=0; legal i_boot_start -> LOAD next cycle.
REQ-021 LOAD: o_boot_ready=1, o_core_rst=1; a word is accepted on the cycle in which i_boot_valid & o_boot_ready = 1.
REQ-022 On acceptance, o_imem_we SHALL equal 1 combinationally, o_imem_wdata = i_boot_data, o_imem_waddr = current word counter; the counter SHALL then increment.
REQ-023 On acceptance of word number len (counter == len-1), LOAD -> RELEASE; no further word SHALL be accepted.
REQ-024 RELEASE: lasts exactly one cycle, o_boot_done=1, o_core_rst=1, o_boot_ready=0; -> RUN.
REQ-025 RUN: o_core_rst=0, o_boot_ready=0, o_imem_we=0; legal i_boot_start -> LOAD (reload, core re-enters reset on the next cycle).
REQ-026 o_imem_raddr SHALL equal i_core_faddr in RUN and o_imem_waddr in all other states.
REQ-027 On entry to LOAD, the word counter SHALL clear to 0 and the length SHALL be latched from i_boot_len.
REQ-028 i_boot_len == 0 or > 2**AW with i_boot_start: o_boot_err=1 next cycle, state unchanged.
REQ-029 i_boot_start while in LOAD or RELEASE: ignored, o_boot_err=1 next cycle, load continues undisturbed.
REQ-030 Length 2**AW: last write to address 2**AW-1; counter SHALL NOT wrap into address 0 before RELEASE.
REQ-031 In LOAD, i_boot_valid=0 stalls indefinitely with no write and no counter change.
REQ-032 o_boot_done and o_boot_err SHALL never be high for more than one consecutive cycle per event.

Reset
REQ-033 Asserting i_rst SHALL immediately force IDLE, counter 0, latched length 0, o_core_rst=1, o_boot_ready=0, o_imem_we=0, o_boot_done=0, o_boot_err=0, o_imem_waddr=0.
REQ-034 i_rst asserted mid-LOAD SHALL abort the load; after release the block waits in IDLE for a new i_boot_start.

Verification
REQ-035 Reset, start len=4, words A0..A3 back-to-back -> writes at addr 0..3, o_boot_done one cycle after 4th word, o_core_rst falls the cycle after.
REQ-036 len=3 with valid gaps of 0,2,5 cycles -> exactly 3 writes at addr 0,1,2; no write during gaps.
REQ-037 start with len=0 in IDLE -> o_boot_err pulse, state stays IDLE, no o_boot_ready.
REQ-038 start during LOAD (len=8, after 3 words) -> o_boot_err pulse; remaining 5 words still land at addr 3..7.
REQ-039 In RUN, i_core_faddr sweep 0..15 -> o_imem_raddr follows; then start len=2 -> o_core_rst=1 next cycle, reload to addr 0,1, return to RUN.
REQ-040 i_rst pulse after 2 of 6 words -> all outputs at reset values immediately, IDLE, o_boot_ready=0 until next start; full-depth load (len=2**AW) ends at addr 2**AW-1.
